// File: rtl/clock_reconfig_sequencer.sv
// Sequences an ICS644 clock change: hold the video pipeline and PLL in reset, drive the
// new S setting, let the PLL settle and relock, then release video reset.
module clock_reconfig_sequencer #(
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES       = 1024,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_WIDTH           = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       config_changed,
    input  logic [3:0] clock_config_S_in,
    input  logic       pll_locked,
    output logic [3:0] clock_config_S_out,
    output logic       pll_reset,
    output logic       video_reset,
    output logic       reconfig_busy,
    output logic       reconfig_done,
    output logic       lock_timeout
);

    typedef enum logic [2:0] {IDLE, HOLD, APPLY, SETTLE, WAIT_LOCK, RELEASE} state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);

    state_t               state, next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] stable_cnt;
    logic                 pending;
    logic                 locked_meta, locked_s;
    logic                 pll_reset_nxt, video_reset_nxt, busy_nxt, done_nxt, lock_timeout_nxt;

    // pll_locked comes from the PLL's own clock domain; only locked_s is used downstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= HOLD;
            cnt                <= '0;
            stable_cnt         <= '0;
            pending            <= 1'b0;
            clock_config_S_out <= 4'b0000;
            pll_reset          <= 1'b1;
            video_reset        <= 1'b1;
            reconfig_busy      <= 1'b1;
            reconfig_done      <= 1'b0;
            lock_timeout       <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= (next_state != state) ? '0 : cnt + 1'b1;
            stable_cnt <= (state == WAIT_LOCK && next_state == WAIT_LOCK && locked_s)
                          ? stable_cnt + 1'b1 : '0;
            if (state == APPLY)
                pending <= config_changed;
            else if (state != IDLE && config_changed)
                pending <= 1'b1;
            if (state == APPLY)
                clock_config_S_out <= clock_config_S_in;
            pll_reset     <= pll_reset_nxt;
            video_reset   <= video_reset_nxt;
            reconfig_busy <= busy_nxt;
            reconfig_done <= done_nxt;
            lock_timeout  <= lock_timeout_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (config_changed || !locked_s) next_state = HOLD;
            HOLD:      if (cnt == HOLD_LAST) next_state = APPLY;
            APPLY:     next_state = SETTLE;
            SETTLE:    if (cnt == SETTLE_LAST) next_state = WAIT_LOCK;
            WAIT_LOCK: begin
                // Stable lock takes priority over a timeout landing in the same cycle.
                if (locked_s && stable_cnt == STABLE_LAST) next_state = RELEASE;
                else if (cnt == TIMEOUT_LAST)              next_state = HOLD;
            end
            RELEASE:   next_state = (pending || config_changed) ? HOLD : IDLE;
            default:   next_state = HOLD;
        endcase
    end

    // Outputs are registered from the upcoming state so the pins never glitch on decode.
    always_comb begin
        pll_reset_nxt    = (next_state == HOLD) || (next_state == APPLY) || (next_state == SETTLE);
        video_reset_nxt  = (next_state != IDLE);
        busy_nxt         = (next_state != IDLE);
        done_nxt         = (state == RELEASE) && (next_state == IDLE);
        lock_timeout_nxt = lock_timeout;
        if (state == WAIT_LOCK && next_state == HOLD)
            lock_timeout_nxt = 1'b1;
        else if (done_nxt)
            lock_timeout_nxt = 1'b0;
    end

endmodule
